// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the restoring/non-restoring divider sequencer:
// FSM state encoding and adder-operand mux select codes.
package div_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_ADD  = 2'd1;
    localparam logic [1:0] SEL_LOAD = 2'd2;
    localparam logic [1:0] SEL_SUB  = 2'd3;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider sequencer: counts completed iterations,
// saturates at WIDTH and flags the last iteration (count == WIDTH-1).
module div_iter_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_LAST);

endmodule

// File: rtl/div_seq_controller.sv
// Control FSM for a bit-serial divider: loads operands, runs one shift/add-or-
// subtract iteration per quotient bit, optionally corrects the remainder.
//
// state | meaning
// IDLE  | waiting for start, all controls low
// LOAD  | load operands, latch divide-by-zero flag
// ITER  | one quotient bit per cycle, add/subtract chosen by remainder sign
// FIX   | restore a negative final remainder (FIX_EN only)
// DONE  | result valid until ack or a new start
module div_seq_controller
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int FIX_EN = 1,
    parameter int CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic             divzero,
    input  logic             ack,
    output logic             load,
    output logic             shift,
    output logic             add,
    output logic             inbit,
    output logic [1:0]       sel,
    output logic             valid,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    state_e state;
    state_e state_nxt;
    logic   cnt_clear;
    logic   cnt_tc;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (start)        state_nxt = ST_LOAD;
                else if (divzero) state_nxt = ST_DONE;
                else              state_nxt = ST_ITER;
            end
            ST_ITER: begin
                if (start)       state_nxt = ST_LOAD;
                else if (cnt_tc) state_nxt = (FIX_EN != 0) ? ST_FIX : ST_DONE;
            end
            ST_FIX:  state_nxt = start ? ST_LOAD : ST_DONE;
            ST_DONE: begin
                if (start)    state_nxt = ST_LOAD;
                else if (ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_LOAD) err <= divzero;
        end
    end

    // Count restarts from zero on every new operation and when returning to idle.
    assign cnt_clear = (state_nxt == ST_LOAD) || (state_nxt == ST_IDLE) || (state == ST_LOAD);

    div_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (state == ST_ITER),
        .count  (count),
        .tc     (cnt_tc)
    );

    always_comb begin
        load  = 1'b0;
        shift = 1'b0;
        add   = 1'b0;
        inbit = 1'b0;
        sel   = SEL_HOLD;
        valid = 1'b0;
        busy  = 1'b0;
        unique case (state)
            ST_IDLE: ;
            ST_LOAD: begin
                load = 1'b1;
                sel  = SEL_LOAD;
                busy = 1'b1;
            end
            ST_ITER: begin
                shift = 1'b1;
                busy  = 1'b1;
                add   = sign;
                inbit = ~sign;
                sel   = sign ? SEL_ADD : SEL_SUB;
            end
            ST_FIX: begin
                busy = 1'b1;
                add  = sign;
                sel  = sign ? SEL_ADD : SEL_HOLD;
            end
            ST_DONE: valid = 1'b1;
            default: ;
        endcase
    end

endmodule
